// File: rtl/sdf_march_controller.sv
// Ray-march initiator: issues SDF sample points along one ray and reports hit/miss/steps.
// Optional SDF response watchdog enabled by defining SDF_TIMEOUT_EN.
module sdf_march_controller #(
  parameter int MAX_STEPS      = 64,
  parameter int HIT_EPS        = 32'sh0000_0100,
  parameter int MAX_DIST       = 32'sh0064_0000,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int STEP_W        = $clog2(MAX_STEPS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [95:0]       ray_origin,
  input  logic [95:0]       ray_dir,
  output logic              sdf_req,
  output logic [95:0]       sdf_point,
  input  logic              sdf_resp,
  input  logic [31:0]       sdf_distance,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              result_hit,
  output logic [31:0]       result_t,
  output logic [STEP_W-1:0] result_steps,
  output logic              result_timeout,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  // fp is signed Q16.16; vec3 packs x in [31:0], y in [63:32], z in [95:64].
  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // initiator holds data stable while valid is high and not yet accepted.

  if (MAX_STEPS < 1) begin : g_bad_max_steps
    $error("MAX_STEPS must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_EVAL  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic signed [31:0] fp_mul(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
    return 32'(((64)'(a) * (64)'(b)) >>> 16);
  endfunction

  function automatic logic [95:0] vec3_scaled(input logic [95:0] v,
                                              input logic signed [31:0] s);
    logic [95:0] r;
    for (int i = 0; i < 3; i++) r[i*32 +: 32] = fp_mul(v[i*32 +: 32], s);
    return r;
  endfunction

  function automatic logic [95:0] vec3_add(input logic [95:0] a, input logic [95:0] b);
    logic [95:0] r;
    for (int i = 0; i < 3; i++) r[i*32 +: 32] = a[i*32 +: 32] + b[i*32 +: 32];
    return r;
  endfunction

  function automatic logic signed [31:0] fp_add_sat(input logic signed [31:0] a,
                                                    input logic signed [31:0] b);
    logic signed [32:0] s;
    s = 33'(a) + 33'(b);
    if (s[32] != s[31]) return s[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    return s[31:0];
  endfunction

  state_t              state_q, state_d;
  logic [95:0]         origin_q, origin_d;
  logic [95:0]         dir_q, dir_d;
  logic signed [31:0]  t_q, t_d;
  logic signed [31:0]  d_q, d_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic                sdf_req_q, sdf_req_d;
  logic [95:0]         sdf_point_q, sdf_point_d;
  logic                res_valid_q, res_valid_d;
  logic                res_hit_q, res_hit_d;
  logic [31:0]         res_t_q, res_t_d;
  logic [STEP_W-1:0]   res_steps_q, res_steps_d;
  logic signed [31:0]  t_next;

`ifdef SDF_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            res_timeout_q, res_timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    origin_d    = origin_q;
    dir_d       = dir_q;
    t_d         = t_q;
    d_d         = d_q;
    steps_d     = steps_q;
    sdf_req_d   = 1'b0;
    sdf_point_d = sdf_point_q;
    res_valid_d = res_valid_q;
    res_hit_d   = res_hit_q;
    res_t_d     = res_t_q;
    res_steps_d = res_steps_q;
    t_next      = fp_add_sat(t_q, d_q);
`ifdef SDF_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    res_timeout_d = res_timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          origin_d = ray_origin;
          dir_d    = ray_dir;
          t_d      = '0;
          steps_d  = '0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        sdf_point_d = vec3_add(origin_q, vec3_scaled(dir_q, t_q));
        sdf_req_d   = 1'b1;
        state_d     = S_WAIT;
`ifdef SDF_TIMEOUT_EN
        to_cnt_d    = '0;
`endif
      end
      S_WAIT: begin
        if (sdf_resp) begin
          d_d     = sdf_distance;
          steps_d = steps_q + STEP_W'(1);
          state_d = S_EVAL;
        end
`ifdef SDF_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES)) begin
          res_valid_d   = 1'b1;
          res_hit_d     = 1'b0;
          res_t_d       = t_q;
          res_steps_d   = steps_q;
          res_timeout_d = 1'b1;
          state_d       = S_DONE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      S_EVAL: begin
        // Saturated t+d can never be <= MAX_DIST, so saturation ends as a miss.
        if (d_q < HIT_EPS || t_next > MAX_DIST || steps_q == STEP_W'(MAX_STEPS)) begin
          res_valid_d = 1'b1;
          res_hit_d   = (d_q < HIT_EPS);
          res_t_d     = t_q;
          res_steps_d = steps_q;
`ifdef SDF_TIMEOUT_EN
          res_timeout_d = 1'b0;
`endif
          state_d     = S_DONE;
        end else begin
          t_d     = t_next;
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        if (result_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      origin_q    <= '0;
      dir_q       <= '0;
      t_q         <= '0;
      d_q         <= '0;
      steps_q     <= '0;
      sdf_req_q   <= 1'b0;
      sdf_point_q <= '0;
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_t_q     <= '0;
      res_steps_q <= '0;
    end else begin
      state_q     <= state_d;
      origin_q    <= origin_d;
      dir_q       <= dir_d;
      t_q         <= t_d;
      d_q         <= d_d;
      steps_q     <= steps_d;
      sdf_req_q   <= sdf_req_d;
      sdf_point_q <= sdf_point_d;
      res_valid_q <= res_valid_d;
      res_hit_q   <= res_hit_d;
      res_t_q     <= res_t_d;
      res_steps_q <= res_steps_d;
    end
  end

`ifdef SDF_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q      <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      res_timeout_q <= res_timeout_d;
    end
  end
  assign result_timeout = res_timeout_q;
`else
  assign result_timeout = 1'b0;
`endif

  // start_ready is masked while rst is held so no ray is offered during reset.
  assign start_ready  = (state_q == S_IDLE) && !rst;
  assign busy         = (state_q != S_IDLE);
  assign sdf_req      = sdf_req_q;
  assign sdf_point    = sdf_point_q;
  assign result_valid = res_valid_q;
  assign result_hit   = res_hit_q;
  assign result_t     = res_t_q;
  assign result_steps = res_steps_q;
  assign dbg_state    = state_q;

endmodule
